// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write dual-read register file with zero register, bypass and busy scoreboard
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              RegWr0,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [WIDTH-1:0]  BusW0,
  input  logic              RegWr1,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [WIDTH-1:0]  BusW1,
  input  logic              IssueVld,
  input  logic [ADDR_W-1:0] IssueRd
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic              BYP_EN    = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic hit0_a, hit1_a, hit0_b, hit1_b;

  // Next storage: port 0 first, then port 1 so a same-address conflict resolves to port 1
  always_comb begin
    mem_d = mem_q;
    if (RegWr0 && (RW0 != ZERO_ADDR)) mem_d[RW0] = BusW0;
    if (RegWr1 && (RW1 != ZERO_ADDR)) mem_d[RW1] = BusW1;
  end

  // Next scoreboard: writebacks retire producers, a new issue applied last so it supersedes them
  always_comb begin
    busy_d = busy_q;
    if (RegWr0) busy_d[RW0] = 1'b0;
    if (RegWr1) busy_d[RW1] = 1'b0;
    if (IssueVld && (IssueRd != ZERO_ADDR)) busy_d[IssueRd] = 1'b1;
    busy_d[ZERO_ADDR] = 1'b0;
  end

  // State registers; reset clears contents and drops every pending producer
  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q <= busy_d;
    end
  end

  // Same-cycle write hits used for forwarding (only when bypass is built in)
  always_comb begin
    hit0_a = BYP_EN && RegWr0 && (RW0 == RA);
    hit1_a = BYP_EN && RegWr1 && (RW1 == RA);
    hit0_b = BYP_EN && RegWr0 && (RW0 == RB);
    hit1_b = BYP_EN && RegWr1 && (RW1 == RB);
  end

  // Read port A: zero register, then forwarded write (port 1 first), then stored word
  always_comb begin
    BusA = mem_q[RA];
    if (hit1_a)      BusA = BusW1;
    else if (hit0_a) BusA = BusW0;
    if (RA == ZERO_ADDR) BusA = '0;
    BusyA = busy_q[RA] && !hit0_a && !hit1_a && (RA != ZERO_ADDR);
  end

  // Read port B: identical selection to port A
  always_comb begin
    BusB = mem_q[RB];
    if (hit1_b)      BusB = BusW1;
    else if (hit0_b) BusB = BusW0;
    if (RB == ZERO_ADDR) BusB = '0;
    BusyB = busy_q[RB] && !hit0_b && !hit1_b && (RB != ZERO_ADDR);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp
module tb_regfile_mp;

  logic        Clk = 1'b0;
  logic        ResetL = 1'b0;

  logic [4:0]  RA, RB, RW0, RW1, IssueRd;
  logic [63:0] BusW0, BusW1;
  logic        RegWr0, RegWr1, IssueVld;
  logic [63:0] BusA, BusB, nb_BusA, nb_BusB;
  logic        BusyA, BusyB, nb_BusyA, nb_BusyB;

  logic [3:0]  s_RA, s_RB, s_RW0, s_RW1, s_IssueRd;
  logic [31:0] s_BusW0, s_BusW1, s_BusA, s_BusB;
  logic        s_RegWr0, s_RegWr1, s_IssueVld, s_BusyA, s_BusyB;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  regfile_mp dut (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .BusyA(BusyA), .BusyB(BusyB), .RegWr0(RegWr0), .RW0(RW0), .BusW0(BusW0),
    .RegWr1(RegWr1), .RW1(RW1), .BusW1(BusW1), .IssueVld(IssueVld), .IssueRd(IssueRd)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .BusA(nb_BusA), .BusB(nb_BusB),
    .BusyA(nb_BusyA), .BusyB(nb_BusyB), .RegWr0(RegWr0), .RW0(RW0), .BusW0(BusW0),
    .RegWr1(RegWr1), .RW1(RW1), .BusW1(BusW1), .IssueVld(IssueVld), .IssueRd(IssueRd)
  );

  regfile_mp #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_s (
    .Clk(Clk), .ResetL(ResetL), .RA(s_RA), .RB(s_RB), .BusA(s_BusA), .BusB(s_BusB),
    .BusyA(s_BusyA), .BusyB(s_BusyB), .RegWr0(s_RegWr0), .RW0(s_RW0), .BusW0(s_BusW0),
    .RegWr1(s_RegWr1), .RW1(s_RW1), .BusW1(s_BusW1), .IssueVld(s_IssueVld), .IssueRd(s_IssueRd)
  );

  typedef struct {
    logic        w0; logic [4:0] a0; logic [63:0] d0;
    logic        w1; logic [4:0] a1; logic [63:0] d1;
    logic        iv; logic [4:0] ird;
    logic [4:0]  ra; logic [4:0] rb;
    logic [63:0] ea; logic [63:0] eb;
    logic        ya; logic        yb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                     input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                     input logic iv, input logic [4:0] ird,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input logic [63:0] ea, input logic [63:0] eb,
                     input logic ya, input logic yb);
    vec_t v;
    v.w0 = w0; v.a0 = a0; v.d0 = d0; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.iv = iv; v.ird = ird; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.ya = ya; v.yb = yb;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    RegWr0 = 0; RW0 = 0; BusW0 = 0; RegWr1 = 0; RW1 = 0; BusW1 = 0;
    IssueVld = 0; IssueRd = 0;
    s_RegWr0 = 0; s_RW0 = 0; s_BusW0 = 0; s_RegWr1 = 0; s_RW1 = 0; s_BusW1 = 0;
    s_IssueVld = 0; s_IssueRd = 0;
  endtask

  // Move to the middle of the next low phase (one rising edge passes)
  task automatic next_cycle();
    @(negedge Clk);
  endtask

  initial begin
    idle();
    RA = 0; RB = 0; s_RA = 0; s_RB = 0;
    ResetL = 0;
    repeat (2) @(posedge Clk);
    next_cycle();
    ResetL = 1;

    // Reset with pending state: write r3, issue r4, then reset while writing and issuing
    RegWr0 = 1; RW0 = 3; BusW0 = 64'hDEAD; IssueVld = 1; IssueRd = 4;
    next_cycle();
    idle(); RA = 3; RB = 4; #1;
    chk("pre_reset_r3", BusA, 64'hDEAD);
    chk("pre_reset_busy_r4", 64'(BusyB), 64'd1);
    ResetL = 0; RegWr0 = 1; RW0 = 3; BusW0 = 64'hBEEF; IssueVld = 1; IssueRd = 6;
    next_cycle();
    ResetL = 1; idle(); #1;
    chk("reset_r3", BusA, 64'h0);
    chk("reset_busy_r3", 64'(BusyA), 64'd0);
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(i); #1;
      chk($sformatf("reset_rd_r%0d", i), BusA, 64'h0);
      chk($sformatf("reset_busy_r%0d", i), 64'(BusyB), 64'd0);
    end

    // Per-cycle vectors on the BYPASS=1 instance; expectations are pre-edge values
    //   w0 a0  d0                     w1 a1  d1                     iv ird  ra  rb  ea                     eb                     ya yb
    add(1, 31, 64'h1234,               0, 0,  0,                     1, 31, 31, 31, 0,                     0,                     0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  31, 31, 0,                     0,                     0, 0);
    add(1, 5,  64'hAAAA,               1, 5,  64'hBBBB,              0, 0,  5,  5,  64'hBBBB,              64'hBBBB,              0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  5,  31, 64'hBBBB,              0,                     0, 0);
    add(1, 7,  64'h77,                 0, 0,  0,                     0, 0,  7,  5,  64'h77,                64'hBBBB,              0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  7,  7,  64'h77,                64'h77,                0, 0);
    add(0, 0,  0,                      0, 0,  0,                     1, 9,  9,  9,  0,                     0,                     0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  9,  7,  0,                     64'h77,                1, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  9,  9,  0,                     0,                     1, 1);
    add(0, 0,  0,                      1, 9,  64'h99,                0, 0,  9,  9,  64'h99,                64'h99,                0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  9,  9,  64'h99,                64'h99,                0, 0);
    add(1, 9,  64'h55,                 0, 0,  0,                     1, 9,  9,  9,  64'h55,                64'h55,                0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  9,  9,  64'h55,                64'h55,                1, 1);
    add(1, 9,  64'h66,                 1, 10, 64'hFFFF000012345678,  0, 0,  10, 9,  64'hFFFF000012345678,  64'h66,                0, 0);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  9,  10, 64'h66,                64'hFFFF000012345678,  0, 0);
    add(0, 0,  0,                      0, 0,  0,                     1, 12, 12, 12, 0,                     0,                     0, 0);
    add(0, 0,  0,                      0, 0,  0,                     1, 13, 12, 13, 0,                     0,                     1, 0);
    add(1, 12, 64'hC,                  0, 0,  0,                     0, 0,  12, 13, 64'hC,                 0,                     0, 1);
    add(0, 0,  0,                      0, 0,  0,                     0, 0,  12, 13, 64'hC,                 0,                     0, 1);

    foreach (vq[k]) begin
      RegWr0 = vq[k].w0; RW0 = vq[k].a0; BusW0 = vq[k].d0;
      RegWr1 = vq[k].w1; RW1 = vq[k].a1; BusW1 = vq[k].d1;
      IssueVld = vq[k].iv; IssueRd = vq[k].ird;
      RA = vq[k].ra; RB = vq[k].rb;
      #1;
      chk($sformatf("v%0d_busa", k), BusA, vq[k].ea);
      chk($sformatf("v%0d_busb", k), BusB, vq[k].eb);
      chk($sformatf("v%0d_busya", k), 64'(BusyA), 64'(vq[k].ya));
      chk($sformatf("v%0d_busyb", k), 64'(BusyB), 64'(vq[k].yb));
      next_cycle();
    end
    idle();

    // Bypass against no-bypass on a freshly reset pair of instances
    ResetL = 0;
    next_cycle();
    ResetL = 1;
    RegWr0 = 1; RW0 = 7; BusW0 = 64'h77; RA = 7; RB = 7; #1;
    chk("byp_r7_write_cycle", BusA, 64'h77);
    chk("nobyp_r7_write_cycle", nb_BusA, 64'h0);
    next_cycle();
    idle(); #1;
    chk("nobyp_r7_after", nb_BusA, 64'h77);
    IssueVld = 1; IssueRd = 9;
    next_cycle();
    idle(); RegWr1 = 1; RW1 = 9; BusW1 = 64'h909; RA = 9; #1;
    chk("nobyp_busy_in_write", 64'(nb_BusyA), 64'd1);
    chk("nobyp_old_in_write", nb_BusA, 64'h0);
    chk("byp_busy_in_write", 64'(BusyA), 64'd0);
    next_cycle();
    idle(); #1;
    chk("nobyp_busy_after", 64'(nb_BusyA), 64'd0);
    chk("nobyp_data_after", nb_BusA, 64'h909);

    // Narrow instance with zero register at index 0
    s_RegWr0 = 1; s_RW0 = 15; s_BusW0 = 32'hFFFFFFFF;
    s_RegWr1 = 1; s_RW1 = 0;  s_BusW1 = 32'h1234;
    s_IssueVld = 1; s_IssueRd = 0; s_RA = 0; s_RB = 15; #1;
    chk("s_r0_write_cycle", 64'(s_BusA), 64'h0);
    chk("s_r15_bypass", 64'(s_BusB), 64'hFFFFFFFF);
    next_cycle();
    idle(); #1;
    chk("s_r0_after", 64'(s_BusA), 64'h0);
    chk("s_r0_busy", 64'(s_BusyA), 64'd0);
    chk("s_r15_after", 64'(s_BusB), 64'hFFFFFFFF);
    s_RegWr0 = 1; s_RW0 = 15; s_BusW0 = 32'h11111111;
    s_RegWr1 = 1; s_RW1 = 15; s_BusW1 = 32'h22222222;
    next_cycle();
    idle(); #1;
    chk("s_r15_conflict", 64'(s_BusB), 64'h22222222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
